// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet layout helpers: field offsets, VC count and occupancy width.
// Used by both the depacketizer buffer and the packetizer side of the fabric.
package noc_pkt_pkg;

    localparam int DEF_ADDRESS_WIDTH    = 4;
    localparam int DEF_VC_ADDRESS_WIDTH = 1;
    localparam int DEF_WIDTH_DATA       = 16;
    localparam int DEF_DEPTH_PER_VC     = 16;

    // VC field sits directly above the payload
    function automatic int vc_lsb(input int width_data);
        return width_data;
    endfunction

    function automatic int dest_lsb(input int width_data, input int vc_address_width);
        return width_data + vc_address_width;
    endfunction

    function automatic int num_vc(input int vc_address_width);
        return 32'sd1 << vc_address_width;
    endfunction

    // Occupancy needs one extra bit so that a completely full buffer is representable
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 32'sd1;
    endfunction

endpackage

// File: rtl/vc_sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy; one instance per VC.
// Push is refused when full even if a pop happens in the same cycle.
module vc_sync_fifo
    import noc_pkt_pkg::*;
#(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == CNT_W'(0));
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; contents are don't-care until a pointer covers them
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= PTR_W'(0);
            r_rd_ptr <= PTR_W'(0);
            r_count  <= CNT_W'(0);
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vc_depacketizer_buf.sv
// Receives fabric packet words, checks the destination and demuxes the payload
// into one independent FIFO per virtual channel.
module vc_depacketizer_buf
    import noc_pkt_pkg::*;
#(
    parameter  int ADDRESS_WIDTH    = DEF_ADDRESS_WIDTH,
    parameter  int VC_ADDRESS_WIDTH = DEF_VC_ADDRESS_WIDTH,
    parameter  int WIDTH_PKT        = 512,
    parameter  int WIDTH_DATA       = DEF_WIDTH_DATA,
    parameter  int DEPTH_PER_VC     = DEF_DEPTH_PER_VC,
    parameter  int NODE_ID          = 1,
    localparam int NUM_VC           = num_vc(VC_ADDRESS_WIDTH),
    localparam int CNT_W            = cnt_w(DEPTH_PER_VC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_PKT-1:0]  i_packet_in,
    input  logic                  i_valid_in,
    output logic                  i_ready_out,
    output logic [WIDTH_DATA-1:0] o_data_out  [NUM_VC],
    output logic                  o_valid_out [NUM_VC],
    input  logic                  o_ready_in  [NUM_VC],
    output logic [CNT_W-1:0]      o_count     [NUM_VC],
    output logic                  o_err_dest
);

    localparam int VC_LSB   = vc_lsb(WIDTH_DATA);
    localparam int DEST_LSB = dest_lsb(WIDTH_DATA, VC_ADDRESS_WIDTH);

    logic [WIDTH_DATA-1:0]       w_data;
    logic [VC_ADDRESS_WIDTH-1:0] w_vc;
    logic [ADDRESS_WIDTH-1:0]    w_dest;
    logic                        w_dest_ok;
    logic                        w_accept;
    logic [NUM_VC-1:0]           w_push;
    logic [NUM_VC-1:0]           w_full;
    logic [NUM_VC-1:0]           w_empty;
    logic                        r_err_dest;
    logic                        w_unused;

    assign w_data    = i_packet_in[WIDTH_DATA-1:0];
    assign w_vc      = i_packet_in[VC_LSB +: VC_ADDRESS_WIDTH];
    assign w_dest    = i_packet_in[DEST_LSB +: ADDRESS_WIDTH];
    assign w_unused  = &{1'b0, i_packet_in};
    assign w_dest_ok = (w_dest == ADDRESS_WIDTH'(NODE_ID));

    // Ready follows only the addressed VC so a stalled VC never blocks the others
    assign i_ready_out = !w_full[w_vc];
    assign w_accept    = i_valid_in && i_ready_out;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign w_push[v]      = w_accept && w_dest_ok && (w_vc == VC_ADDRESS_WIDTH'(v));
        assign o_valid_out[v] = !w_empty[v];

        vc_sync_fifo #(
            .WIDTH (WIDTH_DATA),
            .DEPTH (DEPTH_PER_VC)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .i_push  (w_push[v]),
            .i_data  (w_data),
            .i_pop   (o_ready_in[v]),
            .o_data  (o_data_out[v]),
            .o_full  (w_full[v]),
            .o_empty (w_empty[v]),
            .o_count (o_count[v])
        );
    end

    // Sticky misrouted-packet flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_dest <= 1'b0;
        end else if (w_accept && !w_dest_ok) begin
            r_err_dest <= 1'b1;
        end else begin
            r_err_dest <= r_err_dest;
        end
    end

    assign o_err_dest = r_err_dest;

endmodule

// File: tb/tb_vc_depacketizer_buf.sv
// Directed bench for vc_depacketizer_buf: per-cycle queue model plus hand-computed
// checks for single packet, fill/stall, full-with-pop, wrong dest, traffic, reset.
module tb_vc_depacketizer_buf;

    logic         clk;
    logic         rst;
    logic [511:0] pkt;
    logic         valid;
    logic         ready_out;
    logic [15:0]  data_out  [2];
    logic         valid_out [2];
    logic         rdy       [2];
    logic [4:0]   count     [2];
    logic         err_dest;

    int n_checks;
    int n_err;

    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    logic        m_err;
    logic        m_acc;

    vc_depacketizer_buf dut (
        .clk         (clk),
        .rst         (rst),
        .i_packet_in (pkt),
        .i_valid_in  (valid),
        .i_ready_out (ready_out),
        .o_data_out  (data_out),
        .o_valid_out (valid_out),
        .o_ready_in  (rdy),
        .o_count     (count),
        .o_err_dest  (err_dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] dest, input logic vc, input logic [15:0] data);
        pkt        = '1;
        pkt[15:0]  = data;
        pkt[16]    = vc;
        pkt[20:17] = dest;
        valid      = 1'b1;
    endtask

    // Check outputs against the queue model, then advance one clock and update the model
    task automatic tick();
        logic p0, p1, ok;
        #1;
        chk("valid0", 32'(valid_out[0]), 32'(q0.size() != 0));
        chk("valid1", 32'(valid_out[1]), 32'(q1.size() != 0));
        chk("count0", 32'(count[0]), 32'(q0.size()));
        chk("count1", 32'(count[1]), 32'(q1.size()));
        chk("err", 32'(err_dest), 32'(m_err));
        chk("ready", 32'(ready_out), 32'(pkt[16] ? (q1.size() != 16) : (q0.size() != 16)));
        if (q0.size() != 0) chk("data0", 32'(data_out[0]), 32'(q0[0]));
        if (q1.size() != 0) chk("data1", 32'(data_out[1]), 32'(q1[0]));
        @(posedge clk);
        m_acc = 1'b0;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_err = 1'b0;
        end else begin
            ok    = pkt[16] ? (q1.size() != 16) : (q0.size() != 16);
            m_acc = valid && ok;
            p0    = rdy[0] && (q0.size() != 0);
            p1    = rdy[1] && (q1.size() != 0);
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (m_acc && pkt[20:17] != 4'd1) m_err = 1'b1;
            if (m_acc && pkt[20:17] == 4'd1) begin
                if (pkt[16]) q1.push_back(pkt[15:0]);
                else         q0.push_back(pkt[15:0]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int budget;
        n_checks = 0;
        n_err    = 0;
        m_err    = 1'b0;
        m_acc    = 1'b0;
        rst      = 1'b1;
        valid    = 1'b0;
        pkt      = '0;
        rdy[0]   = 1'b0;
        rdy[1]   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state
        tick();
        #1;
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_count0", 32'(count[0]), 32'd0);
        chk("rst_valid0", 32'(valid_out[0]), 32'd0);
        chk("rst_err", 32'(err_dest), 32'd0);
        rst = 1'b0;

        // Single packet
        drive(4'd1, 1'b0, 16'h00A5);
        tick();
        valid = 1'b0;
        #1;
        chk("single_valid0", 32'(valid_out[0]), 32'd1);
        chk("single_data0", 32'(data_out[0]), 32'h00A5);
        chk("single_valid1", 32'(valid_out[1]), 32'd0);
        rdy[0] = 1'b1;
        tick();
        rdy[0] = 1'b0;

        // Fill vc0 while stalled; vc1 still accepted
        for (int i = 0; i < 16; i++) begin
            drive(4'd1, 1'b0, 16'h0100 + 16'(i));
            tick();
        end
        drive(4'd1, 1'b0, 16'hEEEE);
        #1;
        chk("fill_ready0", 32'(ready_out), 32'd0);
        chk("fill_count0", 32'(count[0]), 32'd16);
        tick();
        drive(4'd1, 1'b1, 16'h0B0B);
        #1;
        chk("fill_ready1", 32'(ready_out), 32'd1);
        tick();
        valid = 1'b0;
        #1;
        chk("fill_count1", 32'(count[1]), 32'd1);
        chk("fill_count0_hold", 32'(count[0]), 32'd16);

        // Full buffer popped while a push is offered: push refused
        drive(4'd1, 1'b0, 16'hFFFF);
        rdy[0] = 1'b1;
        tick();
        valid  = 1'b0;
        rdy[0] = 1'b0;
        #1;
        chk("fullpop_count0", 32'(count[0]), 32'd15);
        chk("fullpop_head0", 32'(data_out[0]), 32'h0101);
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        repeat (16) tick();
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        #1;
        chk("drain_count0", 32'(count[0]), 32'd0);
        chk("drain_count1", 32'(count[1]), 32'd0);

        // Wrong destination
        drive(4'd2, 1'b1, 16'h1234);
        tick();
        valid = 1'b0;
        #1;
        chk("wdest_count1", 32'(count[1]), 32'd0);
        chk("wdest_err", 32'(err_dest), 32'd1);
        repeat (3) tick();
        chk("wdest_sticky", 32'(err_dest), 32'd1);

        // Simultaneous push and pop on a non-empty buffer
        drive(4'd1, 1'b1, 16'hC001);
        tick();
        drive(4'd1, 1'b1, 16'hC002);
        tick();
        drive(4'd1, 1'b1, 16'hC003);
        rdy[1] = 1'b1;
        tick();
        valid  = 1'b0;
        rdy[1] = 1'b0;
        #1;
        chk("pushpop_count1", 32'(count[1]), 32'd2);
        chk("pushpop_head1", 32'(data_out[1]), 32'hC002);
        rdy[1] = 1'b1;
        repeat (2) tick();
        rdy[1] = 1'b0;

        // Random traffic on alternating VCs with random consumer stalls
        sent   = 0;
        budget = 0;
        while (sent < 1000 && budget < 20000) begin
            drive(4'd1, sent[0], 16'($urandom));
            rdy[0] = 1'($urandom_range(0, 1));
            rdy[1] = 1'($urandom_range(0, 1));
            tick();
            if (m_acc) sent++;
            budget++;
        end
        chk("rand_sent", 32'(sent), 32'd1000);
        valid  = 1'b0;
        rdy[0] = 1'b1;
        rdy[1] = 1'b1;
        repeat (20) tick();
        chk("rand_drained0", 32'(count[0]), 32'd0);
        chk("rand_drained1", 32'(count[1]), 32'd0);
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;

        // Mid-run reset discards buffered data and clears the error flag
        for (int i = 0; i < 5; i++) begin
            drive(4'd1, 1'b0, 16'h5000 + 16'(i));
            tick();
        end
        valid = 1'b0;
        #1;
        chk("mid_count0_pre", 32'(count[0]), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_count0", 32'(count[0]), 32'd0);
        chk("mid_valid0", 32'(valid_out[0]), 32'd0);
        chk("mid_err", 32'(err_dest), 32'd0);
        drive(4'd1, 1'b0, 16'h7777);
        tick();
        valid = 1'b0;
        #1;
        chk("mid_first_valid", 32'(valid_out[0]), 32'd1);
        chk("mid_first_data", 32'(data_out[0]), 32'h7777);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
